// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch and data port) sharing one memory port.
// Alternates grants on contention and aborts any access that waits TIMEOUT cycles.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_done,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            err,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;
    typedef enum logic {SRC_I, SRC_D} src_e;

    localparam int            BW         = DW / 8;
    localparam logic [7:0]    TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    src_e            last_q, last_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= SRC_I;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_done     = 1'b0;
        d_done      = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Fetch wins alone, or on contention when data was served last.
                if (if_req && (!d_req || last_q == SRC_D)) begin
                    state_d     = GRANT_I;
                    last_d      = SRC_I;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                end else if (d_req) begin
                    state_d     = GRANT_D;
                    last_d      = SRC_D;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready || cnt_q == TIMEOUT_M1) begin
                    if_done = (state_q == GRANT_I);
                    d_done  = (state_q == GRANT_D);
                    err     = !mem_ready;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_en    = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_done;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_done;
    logic [31:0]   d_rdata;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packed view: en, we, be, addr, wdata, if_done, d_done, err, rdata.
    function automatic logic [127:0] pack(input logic en, input logic we, input logic [3:0] be,
                                          input logic [31:0] addr, input logic [31:0] wdata,
                                          input logic ifd, input logic dd, input logic er,
                                          input logic [31:0] rd);
        return {23'd0, en, we, be, addr, wdata, ifd, dd, er, rd};
    endfunction

    function automatic logic [127:0] obs(input bit use_rd);
        logic [31:0] rd;
        rd = 32'd0;
        if (use_rd) rd = if_done ? if_rdata : (d_done ? d_rdata : 32'd0);
        return pack(mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_done, d_done, err, rd);
    endfunction

    typedef struct {
        bit          do_rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        ready;
        logic [31:0] rdata;
        logic [127:0] exp;
        bit          use_rd;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [3:0] db,
                                input logic rdy, input logic [31:0] rdt,
                                input logic [127:0] e, input bit urd);
        vec_t v;
        v.do_rst = r;  v.if_req = ir; v.if_addr = ia;
        v.d_req = dr;  v.d_we = dw;   v.d_addr = da; v.d_wdata = dwd; v.d_be = db;
        v.ready = rdy; v.rdata = rdt; v.exp = e;     v.use_rd = urd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0;  d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    vec_t vecs[10];

    // Reference model state (transaction level).
    bit          m_busy, m_who, m_last, m_we;
    int          m_waits;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          i_pend, d_pend, i_fin, d_fin;
    int          stall_left;

    initial begin
        rst = 1'b0;
        idle_inputs();
        #1 rst = 1'b1;
        #1 check("reset_async", obs(0), pack(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;

        // Single fetch, then contention alternation D, I, D, I after a fresh reset.
        vecs[0] = mk(1, 1, 32'h10, 0, 0, 0, 0, 0, 1, 32'hCAFE0001,
                     pack(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0), 0);
        vecs[1] = mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 1, 32'hCAFE0001,
                     pack(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 0, 32'hCAFE0001), 1);
        vecs[2] = mk(1, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h1111,
                     pack(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0), 0);
        vecs[3] = mk(0, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h2222,
                     pack(1, 0, 4'hC, 32'h20, 32'h5A5A5A5A, 0, 1, 0, 32'h2222), 1);
        vecs[4] = mk(0, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h3333,
                     pack(0, 0, 4'hC, 32'h20, 32'h5A5A5A5A, 0, 0, 0, 0), 0);
        vecs[5] = mk(0, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h4444,
                     pack(1, 0, 4'hF, 32'h14, 32'h0, 1, 0, 0, 32'h4444), 1);
        vecs[6] = mk(0, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h5555,
                     pack(0, 0, 4'hF, 32'h14, 32'h0, 0, 0, 0, 0), 0);
        vecs[7] = mk(0, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h7777,
                     pack(1, 0, 4'hC, 32'h20, 32'h5A5A5A5A, 0, 1, 0, 32'h7777), 1);
        vecs[8] = mk(0, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h8888,
                     pack(0, 0, 4'hC, 32'h20, 32'h5A5A5A5A, 0, 0, 0, 0), 0);
        vecs[9] = mk(0, 1, 32'h14, 1, 0, 32'h20, 32'h5A5A5A5A, 4'hC, 1, 32'h9999,
                     pack(1, 0, 4'hF, 32'h14, 32'h0, 1, 0, 0, 32'h9999), 1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_rst) pulse_rst();
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req;   d_we = vecs[i].d_we;     d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
            mem_ready = vecs[i].ready; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(vecs[i].use_rd), vecs[i].exp);
            tick();
        end

        // Store with three wait states; mem_* must stay frozen while fetch inputs churn.
        pulse_rst();
        idle_inputs();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        @(negedge clk);
        check("st_idle", obs(0), pack(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        tick();
        for (int k = 1; k <= 4; k++) begin
            mem_ready = (k == 4);
            mem_rdata = $urandom;
            if_addr = $urandom;
            @(negedge clk);
            check($sformatf("st_g%0d", k), obs(0),
                  pack(1, 1, 4'h3, 32'h20, 32'hDEADBEEF, 0, k == 4, 0, 0));
            tick();
        end
        d_req = 0; mem_ready = 0;
        @(negedge clk);
        check("st_after", obs(0), pack(0, 1, 4'h3, 32'h20, 32'hDEADBEEF, 0, 0, 0, 0));
        tick();

        // Timeout: memory never ready, abort on the TO-th grant cycle.
        // Late completion: ready first appears on that same cycle.
        for (int pass = 0; pass < 2; pass++) begin
            pulse_rst();
            idle_inputs();
            d_req = 1; d_we = 0; d_addr = 32'h30; d_be = 4'hF;
            mem_rdata = 32'hA5A50039;
            @(negedge clk);
            check($sformatf("to%0d_idle", pass), obs(0), pack(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
            tick();
            for (int k = 1; k <= TO; k++) begin
                mem_ready = (pass == 1) && (k == TO);
                @(negedge clk);
                check($sformatf("to%0d_g%0d", pass, k), obs((pass == 1) && (k == TO)),
                      pack(1, 0, 4'hF, 32'h30, 32'h0, 0, k == TO, (pass == 0) && (k == TO),
                           ((pass == 1) && (k == TO)) ? 32'hA5A50039 : 32'h0));
                tick();
            end
            d_req = 0; mem_ready = 0;
            @(negedge clk);
            check($sformatf("to%0d_after", pass), obs(0), pack(0, 0, 4'hF, 32'h30, 0, 0, 0, 0, 0));
            tick();
        end

        // Reset in the middle of a fetch grant: no done, next contention goes to D.
        pulse_rst();
        idle_inputs();
        if_req = 1; if_addr = 32'h40;
        tick();
        #1 check("mr_grant", obs(0), pack(1, 0, 4'hF, 32'h40, 0, 0, 0, 0, 0));
        #1 rst = 1'b1;
        #1 check("mr_async", obs(0), pack(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        d_req = 1; d_addr = 32'h50; d_be = 4'hF;
        @(negedge clk);
        check("mr_hold", obs(0), pack(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
        mem_ready = 1; mem_rdata = 32'h40400040;
        @(negedge clk);
        check("mr_idle", obs(0), pack(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        tick();
        @(negedge clk);
        check("mr_grant_d", obs(1), pack(1, 0, 4'hF, 32'h50, 0, 0, 1, 0, 32'h40400040));
        tick();

        // Randomized traffic against the transaction-level model.
        pulse_rst();
        idle_inputs();
        m_busy = 0; m_who = 0; m_last = 0; m_waits = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        i_pend = 0; d_pend = 0; i_fin = 0; d_fin = 0; stall_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [127:0] exp_v;
            bit fin, use_rd;
            if (!i_pend || i_fin) begin
                i_fin = 0;
                i_pend = ($urandom % 3) != 0;
                if_addr = $urandom;
            end
            if (!d_pend || d_fin) begin
                d_fin = 0;
                d_pend = ($urandom % 3) != 0;
                d_we = $urandom; d_addr = $urandom; d_wdata = $urandom; d_be = $urandom;
            end
            if_req = i_pend;
            d_req = d_pend;
            if (stall_left > 0) begin
                mem_ready = 0;
                stall_left--;
            end else begin
                mem_ready = ($urandom % 4) != 0;
                if ($urandom % 48 == 0) stall_left = $urandom_range(10, 25);
            end
            mem_rdata = $urandom;

            @(negedge clk);
            fin    = m_busy && (mem_ready || m_waits == TO - 1);
            use_rd = fin && mem_ready && !(m_who && m_we);
            exp_v  = pack(m_busy, m_we, m_be, m_addr, m_wdata, fin && !m_who, fin && m_who,
                          fin && !mem_ready, use_rd ? mem_rdata : 32'h0);
            check($sformatf("rnd%0d", cyc), obs(use_rd), exp_v);

            if (m_busy) begin
                if (fin) begin
                    m_busy = 0;
                    if (m_who) d_fin = 1; else i_fin = 1;
                end else begin
                    m_waits++;
                end
            end else if (if_req && (!d_req || m_last)) begin
                m_busy = 1; m_who = 0; m_last = 0; m_waits = 0;
                m_we = 0; m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
            end else if (d_req) begin
                m_busy = 1; m_who = 1; m_last = 1; m_waits = 0;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
